// File: rtl/grid_chain_loader_if.sv
// Frame handshake bundle between a frame producer and grid_chain_loader.
// The producer holds the master side and the loader holds the slave side.
interface grid_chain_loader_if #(
    parameter int ROWS      = 4,
    parameter int CHAIN_LEN = 4
);
    logic [ROWS*CHAIN_LEN-1:0] frame_data;
    logic                      frame_valid;
    logic                      frame_verify;
    logic                      frame_ready;

    modport master (
        output frame_data,
        output frame_valid,
        output frame_verify,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
        input  frame_verify,
        output frame_ready
    );
endinterface

// File: rtl/grid_chain_loader.sv
// Shifts one parallel frame into ROWS serial tile chains and can read it back
// out of the chain tails, flagging any row whose readback differs.
module grid_chain_loader #(
    parameter int ROWS      = 4,
    parameter int CHAIN_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    grid_chain_loader_if.slave  frm,
    output logic [ROWS-1:0]     chain_in,
    output logic                chain_en,
    input  logic [ROWS-1:0]     chain_out,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ROWS-1:0]     err_row
);
    localparam int FW = ROWS * CHAIN_LEN;
    localparam int KW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(CHAIN_LEN - 1);
    localparam logic [KW-1:0] K_ZERO = KW'(0);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            verify_q, verify_d;
    logic [ROWS-1:0] chain_in_q, chain_in_d;
    logic            chain_en_q, chain_en_d;
    logic            frame_ready_q, frame_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [ROWS-1:0] err_row_q, err_row_d;

    // Bits of every row that belong on the wire at shift count k: farthest tile first.
    function automatic logic [ROWS-1:0] frame_column(input logic [FW-1:0] f,
                                                     input logic [KW-1:0] k);
        logic [ROWS-1:0] col;
        col = {ROWS{1'b0}};
        for (int r = 0; r < ROWS; r++) begin
            col[r] = f[r*CHAIN_LEN + (CHAIN_LEN - 1 - int'(k))];
        end
        return col;
    endfunction

    // Next-state logic; chain outputs are computed for the coming cycle and registered.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        frame_d    = frame_q;
        verify_d   = verify_q;
        chain_in_d = {ROWS{1'b0}};
        chain_en_d = 1'b0;
        done_d     = 1'b0;
        err_row_d  = err_row_q;

        case (state_q)
            ST_IDLE: begin
                if (frm.frame_valid && frame_ready_q) begin
                    frame_d    = frm.frame_data;
                    verify_d   = frm.frame_verify;
                    err_row_d  = {ROWS{1'b0}};
                    k_d        = K_ZERO;
                    state_d    = ST_LOAD;
                    chain_en_d = 1'b1;
                    chain_in_d = frame_column(frm.frame_data, K_ZERO);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (k_q == K_LAST) begin
                    k_d = K_ZERO;
                    if (verify_q) begin
                        state_d    = ST_READ;
                        chain_en_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    k_d        = k_q + K_ONE;
                    chain_en_d = 1'b1;
                    chain_in_d = frame_column(frame_q, k_q + K_ONE);
                end
            end
            ST_READ: begin
                // chain_out still shows the tail tile as it was before this edge's shift.
                err_row_d = err_row_q | (chain_out ^ frame_column(frame_q, k_q));
                if (k_q == K_LAST) begin
                    k_d     = K_ZERO;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    k_d        = k_q + K_ONE;
                    chain_en_d = 1'b1;
                end
            end
            ST_DONE: begin
                k_d     = K_ZERO;
                state_d = ST_IDLE;
            end
            default: begin
                k_d     = K_ZERO;
                state_d = ST_IDLE;
            end
        endcase

        frame_ready_d = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        error_d       = |err_row_d;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            k_q           <= K_ZERO;
            frame_q       <= {FW{1'b0}};
            verify_q      <= 1'b0;
            chain_in_q    <= {ROWS{1'b0}};
            chain_en_q    <= 1'b0;
            frame_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_row_q     <= {ROWS{1'b0}};
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            frame_q       <= frame_d;
            verify_q      <= verify_d;
            chain_in_q    <= chain_in_d;
            chain_en_q    <= chain_en_d;
            frame_ready_q <= frame_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            err_row_q     <= err_row_d;
        end
    end

    assign frm.frame_ready = frame_ready_q;
    assign chain_in        = chain_in_q;
    assign chain_en        = chain_en_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign err_row         = err_row_q;
endmodule

// File: tb/tb_grid_chain_loader.sv
// Bench for grid_chain_loader: an ideal shift-register grid with fault knobs,
// a table of directed frames, hand-written corner sequences and random frames.
module tb_grid_chain_loader;
    localparam int ROWS = 4;
    localparam int CL   = 4;
    localparam int FW   = ROWS * CL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    grid_chain_loader_if #(.ROWS(ROWS), .CHAIN_LEN(CL)) frm ();

    logic [ROWS-1:0] chain_in, chain_out, err_row;
    logic            chain_en, busy, done, error;

    grid_chain_loader #(.ROWS(ROWS), .CHAIN_LEN(CL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frm       (frm),
        .chain_in  (chain_in),
        .chain_en  (chain_en),
        .chain_out (chain_out),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_row   (err_row)
    );

    // Grid model: tile t of row r is grid[r][t]; tile 0 takes chain_in.
    logic [CL-1:0]   grid [ROWS];
    int              shift_cnt = 0;
    logic [ROWS-1:0] stuck_mask = '0;
    logic [FW-1:0]   flip_mask = '0;

    always @(posedge clk) begin
        if (chain_en) begin
            for (int r = 0; r < ROWS; r++) begin
                grid[r] <= {grid[r][CL-2:0], chain_in[r]} ^
                           ((shift_cnt == CL-1) ? flip_mask[r*CL +: CL] : {CL{1'b0}});
            end
            shift_cnt <= shift_cnt + 1;
        end else begin
            shift_cnt <= 0;
        end
    end

    always_comb begin
        chain_out = '0;
        for (int r = 0; r < ROWS; r++) chain_out[r] = grid[r][CL-1] | stuck_mask[r];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Readback of each row is its loaded contents (frame xor flips), or all ones when stuck.
    function automatic logic [ROWS-1:0] ref_err(input logic [FW-1:0] f, input bit v,
                                                input logic [ROWS-1:0] st,
                                                input logic [FW-1:0] fl);
        logic [ROWS-1:0] e;
        logic [CL-1:0]   row, rb;
        e = '0;
        for (int r = 0; r < ROWS; r++) begin
            row  = f[r*CL +: CL];
            rb   = st[r] ? {CL{1'b1}} : (row ^ fl[r*CL +: CL]);
            e[r] = v && (rb != row);
        end
        return e;
    endfunction

    function automatic logic [FW-1:0] grid_flat();
        logic [FW-1:0] g;
        for (int r = 0; r < ROWS; r++) g[r*CL +: CL] = grid[r];
        return g;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle checks from cycle 1 (just after accept) through the IDLE cycle after done.
    task automatic follow_frame(input logic [FW-1:0] f, input bit v,
                                input logic [FW-1:0] fl, input logic [ROWS-1:0] exp_err);
        int dc;
        logic [ROWS-1:0] ein;
        dc = v ? 2*CL + 1 : CL + 1;
        for (int c = 1; c <= dc + 1; c++) begin
            ein = '0;
            if (c <= CL) for (int r = 0; r < ROWS; r++) ein[r] = f[r*CL + CL - c];
            check("chain_en", 32'(chain_en), 32'((c <= CL) || (v && c <= 2*CL)));
            check("chain_in", 32'(chain_in), 32'(ein));
            check("done", 32'(done), 32'(c == dc));
            check("busy", 32'(busy), 32'(c <= dc));
            check("frame_ready", 32'(frm.frame_ready), 32'(c > dc));
            if (c == CL + 1) check("grid_loaded", 32'(grid_flat()), 32'(f ^ fl));
            if (c >= dc) begin
                check("err_row", 32'(err_row), 32'(exp_err));
                check("error", 32'(error), 32'(|exp_err));
            end
            tick();
        end
    endtask

    task automatic run_frame(input logic [FW-1:0] f, input bit v, input logic [ROWS-1:0] st,
                             input logic [FW-1:0] fl, input logic [ROWS-1:0] exp_err);
        stuck_mask        = st;
        flip_mask         = fl;
        frm.frame_data    = f;
        frm.frame_verify  = v;
        frm.frame_valid   = 1'b1;
        check("ready_before_accept", 32'(frm.frame_ready), 32'd1);
        tick();
        frm.frame_valid  = 1'b0;
        frm.frame_data   = FW'($urandom);
        frm.frame_verify = ~v;
        follow_frame(f, v, fl, exp_err);
    endtask

    typedef struct {
        logic [FW-1:0]   frame;
        bit              verify;
        logic [ROWS-1:0] stuck;
        logic [FW-1:0]   flip;
        logic [ROWS-1:0] exp_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{16'hA5C3, 1'b1, 4'b0000, 16'h0000, 4'b0000};
        vecs[1] = '{16'h0001, 1'b0, 4'b0000, 16'h0000, 4'b0000};
        vecs[2] = '{16'hFFFF, 1'b1, 4'b0000, 16'h0800, 4'b0100};
        vecs[3] = '{16'h5A5A, 1'b1, 4'b0001, 16'h0000, 4'b0001};
        vecs[4] = '{16'h5A5A, 1'b0, 4'b0001, 16'h0000, 4'b0000};
        vecs[5] = '{16'hF0F0, 1'b1, 4'b0010, 16'h0000, 4'b0000};

        frm.frame_data   = '0;
        frm.frame_valid  = 1'b0;
        frm.frame_verify = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(frm.frame_ready), 32'd1);
        check("rst_chain_in", 32'(chain_in), 32'd0);
        check("rst_chain_en", 32'(chain_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_row", 32'(err_row), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].frame, vecs[i].verify, vecs[i].stuck, vecs[i].flip, vecs[i].exp_err);
        end

        // Error result held through idle cycles.
        run_frame(16'hFFFF, 1'b1, 4'b0000, 16'h0800, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            check("hold_err_row", 32'(err_row), 32'h4);
            check("hold_error", 32'(error), 32'd1);
            tick();
        end

        // Valid held high across two frames.
        stuck_mask       = '0;
        flip_mask        = 16'h0800;
        frm.frame_data   = 16'hFFFF;
        frm.frame_verify = 1'b1;
        frm.frame_valid  = 1'b1;
        tick();
        frm.frame_data = 16'h1234;
        for (int c = 1; c <= 2*CL + 1; c++) begin
            check("b2b_ready_low", 32'(frm.frame_ready), 32'd0);
            if (c == CL + 1) flip_mask = '0;
            if (c == 2*CL + 1) begin
                check("b2b_done", 32'(done), 32'd1);
                check("b2b_err_row", 32'(err_row), 32'h4);
            end
            tick();
        end
        check("b2b_ready_high", 32'(frm.frame_ready), 32'd1);
        check("b2b_error_held", 32'(error), 32'd1);
        tick();
        frm.frame_valid = 1'b0;
        check("b2b_error_cleared", 32'(error), 32'd0);
        check("b2b_err_row_cleared", 32'(err_row), 32'd0);
        follow_frame(16'h1234, 1'b1, 16'h0000, 4'b0000);

        // Reset in the middle of LOAD.
        frm.frame_data   = 16'hA5C3;
        frm.frame_verify = 1'b1;
        frm.frame_valid  = 1'b1;
        tick();
        frm.frame_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_chain_en", 32'(chain_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(frm.frame_ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_chain_in", 32'(chain_in), 32'd0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst_no_done", 32'(done), 32'd0);
            check("midrst_idle", 32'(frm.frame_ready), 32'd1);
        end
        run_frame(16'hA5C3, 1'b1, 4'b0000, 16'h0000, 4'b0000);

        // Random frames against the readback model.
        for (int i = 0; i < 24; i++) begin
            logic [FW-1:0]   f, fl;
            logic [ROWS-1:0] st;
            bit              v;
            f  = FW'($urandom);
            v  = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? ROWS'(1 << $urandom_range(0, ROWS-1)) : '0;
            fl = ($urandom_range(0, 2) == 0) ? FW'(1 << $urandom_range(0, FW-1)) : '0;
            run_frame(f, v, st, fl, ref_err(f, v, st, fl));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
